image_mem_arb: RTL and testbench
================================

IMAGE_MEM_ARB -- requirements
Module: image_mem_arb

Interface
REQ-001 The block SHALL have parameter MEM_AWIDTH, default 16, meaning image buffer address width.
REQ-002 The block SHALL have parameter MEM_DWIDTH, default 64, meaning memory word width (GROUP_NB*IMG_WIDTH).
REQ-003 The block SHALL have parameter RD_LATENCY, default 3, meaning fixed memory read latency in cycles, legal range 1..8.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports a_val (in, 1), a_addr (in, MEM_AWIDTH) and a_data (out, MEM_DWIDTH): port A, the image_read port, which is never stalled.
REQ-007 The block SHALL have ports b_val (in, 1), b_we (in, 1), b_addr (in, MEM_AWIDTH), b_wdata (in, MEM_DWIDTH) and b_rdy (out, 1): port B request, host load/readback.
REQ-008 The block SHALL have ports b_rvalid (out, 1) and b_rdata (out, MEM_DWIDTH): port B read response.
REQ-009 The block SHALL have ports mem_val (out, 1), mem_we (out, 1), mem_addr (out, MEM_AWIDTH), mem_wdata (out, MEM_DWIDTH) and mem_rdata (in, MEM_DWIDTH): the shared single-port memory.

Function
REQ-010 Port A SHALL have strict priority: when a_val=1, mem_val=1, mem_we=0 and mem_addr=a_addr in the same cycle, combinationally.
REQ-011 b_rdy SHALL equal ~a_val combinationally; a port B transfer SHALL occur only on a cycle with b_val & b_rdy.
REQ-012 On a port B transfer, mem_val=1, mem_we=b_we, mem_addr=b_addr and mem_wdata=b_wdata; with no transfer, mem_we=0 and mem_val=a_val.
REQ-013 The arbiter SHALL add zero latency: port A data SHALL arrive exactly RD_LATENCY cycles after a_val, so the image_read timing is unchanged.
REQ-014 A tag shift register, RD_LATENCY deep with 2 bits per stage {is_a, is_b_read}, SHALL advance every cycle; B writes enter the pipe as empty stages.
REQ-015 a_data SHALL equal mem_rdata unconditionally; b_rdata SHALL equal mem_rdata; b_rvalid SHALL be 1 only when the pipe output stage has is_b_read=1.
REQ-016 Port B read responses SHALL return in request order, exactly RD_LATENCY cycles after the transfer, and SHALL have no back-pressure.
REQ-017 Back-to-back B transfers SHALL be accepted every cycle while a_val=0, giving full throughput.
REQ-018 If b_val is held while a_val=1, the request SHALL remain pending and SHALL transfer on the first cycle with a_val=0; b_addr, b_we and b_wdata SHALL be held stable by the requester.

Reset
REQ-019 While rst=0: tag pipe cleared, b_rvalid=0, and all stall-counter state zeroed; mem_val, mem_we and b_rdy follow REQ-010..012 from their inputs.
REQ-020 Reads outstanding when reset asserts SHALL be dropped; no b_rvalid SHALL appear after release for pre-reset requests.
REQ-021 Reset release SHALL be usable on the first rising edge after rst goes to 1.

Configuration
REQ-022 Macro IMAGE_ARB_STATS_EN, when defined, SHALL add input stat_clr (1 bit) and output stat_stall (32 bits).
REQ-023 With IMAGE_ARB_STATS_EN defined, stat_stall SHALL count cycles with b_val & ~b_rdy, saturating at 32'hFFFFFFFF, and SHALL be cleared synchronously by stat_clr, with stat_clr taking precedence over the increment.
REQ-024 Without IMAGE_ARB_STATS_EN, those ports and the counter SHALL be absent and the remaining behaviour SHALL be identical.

Verification
REQ-025 Bench: B write addr 5 data 0xAA, idle A, then B read addr 5 -> mem_we=1 for one cycle; b_rvalid=1 and b_rdata=0xAA exactly 3 cycles after the read.
REQ-026 Bench: a_val continuous for 10 cycles with b_val=1 -> b_rdy=0 for all 10 cycles; B transfers on cycle 11; a_data matches the address-echo model at latency 3 with no gaps.
REQ-027 Bench: alternating A and B reads on addresses 0..15 -> responses routed correctly, with no b_rvalid on A slots and order preserved.
REQ-028 Bench: 4 B reads back-to-back with addresses 1,2,3,4 -> b_rvalid high for 4 consecutive cycles with data 1,2,3,4.
REQ-029 Bench: rst asserted 1 cycle after 2 B reads were issued -> no b_rvalid in the 5 cycles after release.
REQ-030 Bench, with IMAGE_ARB_STATS_EN: 7 stalled cycles -> stat_stall=7; stat_clr pulsed in the same cycle as a stall -> stat_stall=0.

Source files
------------

// File: rtl/image_mem_arb.sv
// image_mem_arb
// Arbiter placing a single-port image buffer behind two requesters:
//   port A - image_read stream, strict priority, never stalled, zero added latency
//   port B - host load/readback, takes any cycle A leaves free
// Read data comes straight from the memory to both ports; a short tag pipe,
// advancing in lockstep with the fixed memory read latency, tells which
// returning word belongs to a port B read.
//
// Optional feature: define IMAGE_ARB_STATS_EN to add the stall counter
// (input stat_clr, output stat_stall). Without it the ports and counter
// are absent and the arbitration behaviour is unchanged.
//
// Reset: rst is asynchronous and active-low.
module image_mem_arb #(
    parameter int MEM_AWIDTH = 16,
    parameter int MEM_DWIDTH = 64,
    parameter int RD_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,

    // Port A: image_read, read-only, never stalled
    input  logic                  a_val,
    input  logic [MEM_AWIDTH-1:0] a_addr,
    output logic [MEM_DWIDTH-1:0] a_data,

    // Port B request: host load/readback
    input  logic                  b_val,
    input  logic                  b_we,
    input  logic [MEM_AWIDTH-1:0] b_addr,
    input  logic [MEM_DWIDTH-1:0] b_wdata,
    output logic                  b_rdy,

    // Port B read response, no back-pressure
    output logic                  b_rvalid,
    output logic [MEM_DWIDTH-1:0] b_rdata,

    // Shared single-port memory
    output logic                  mem_val,
    output logic                  mem_we,
    output logic [MEM_AWIDTH-1:0] mem_addr,
    output logic [MEM_DWIDTH-1:0] mem_wdata,
    input  logic [MEM_DWIDTH-1:0] mem_rdata
`ifdef IMAGE_ARB_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [31:0]           stat_stall
`endif
);

    // Bit positions inside one tag stage
    localparam int TAG_B_READ = 0;
    localparam int TAG_IS_A   = 1;

    // One tag per memory cycle in flight; the last stage lines up with the
    // cycle in which mem_rdata carries the answer to that request.
    logic [1:0] tag_pipe [RD_LATENCY];
    logic [1:0] tag_in;
    logic [1:0] tag_out;

    // A port B request is granted only when A leaves the memory idle
    logic b_xfer;
    logic b_read_xfer;

    // Grant and memory command are pure combinational decode of this cycle's
    // requests, so port A sees exactly the memory timing it would see alone.
    always_comb begin
        b_rdy       = ~a_val;
        b_xfer      = b_val & ~a_val;
        b_read_xfer = b_xfer & ~b_we;

        mem_val     = a_val | b_xfer;
        mem_we      = b_xfer & b_we;
        mem_addr    = a_val ? a_addr : b_addr;
        mem_wdata   = b_wdata;

        tag_in             = 2'b00;
        tag_in[TAG_IS_A]   = a_val;
        tag_in[TAG_B_READ] = b_read_xfer;
    end

    // Tag pipe advances every cycle; writes and idle cycles enter as empty
    // stages, and reset drops every read still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_pipe[i] <= 2'b00;
            end
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Route the returning word: A always sees memory data, B is flagged only
    // when the word answers one of its reads.
    always_comb begin
        tag_out  = tag_pipe[RD_LATENCY-1];
        a_data   = mem_rdata;
        b_rdata  = mem_rdata;
        b_rvalid = tag_out[TAG_B_READ] & ~tag_out[TAG_IS_A];
    end

`ifdef IMAGE_ARB_STATS_EN
    logic [31:0] stall_cnt;
    logic        stall_cycle;

    assign stall_cycle = b_val & ~b_rdy;
    assign stat_stall  = stall_cnt;

    // Count cycles where port B waits behind port A; clear wins, and the
    // counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 32'd0;
        end else if (stat_clr) begin
            stall_cnt <= 32'd0;
        end else if (stall_cycle && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_image_mem_arb.sv
// tb_image_mem_arb
// Drives image_mem_arb with directed and random traffic against a simple
// memory with fixed read latency, and predicts every response from a
// transaction-level model: each granted read is answered LAT cycles later
// with the memory contents at request time.
module tb_image_mem_arb;

    localparam int AW  = 16;
    localparam int DW  = 64;
    localparam int LAT = 3;

    logic          clk;
    logic          rst;
    logic          a_val;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          b_val;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_rdy;
    logic          b_rvalid;
    logic [DW-1:0] b_rdata;
    logic          mem_val;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef IMAGE_ARB_STATS_EN
    logic          stat_clr;
    logic [31:0]   stat_stall;
    logic [31:0]   obs_stat;
    logic [31:0]   exp_stat;
    logic [31:0]   model_stall;
`endif

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    image_mem_arb #(
        .MEM_AWIDTH(AW),
        .MEM_DWIDTH(DW),
        .RD_LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_val     (a_val),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_val     (b_val),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_rdy     (b_rdy),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .mem_val   (mem_val),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef IMAGE_ARB_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_stall(stat_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: unwritten words read back as their own address
    logic [DW-1:0] env_mem [int];
    logic [DW-1:0] rd_pipe [LAT];

    assign mem_rdata = rd_pipe[LAT-1];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
        if (mem_val && !mem_we) begin
            rd_pipe[0] <= env_mem.exists(int'(mem_addr)) ? env_mem[int'(mem_addr)] : DW'(mem_addr);
        end else begin
            rd_pipe[0] <= 64'hDEAD_BEEF_0BAD_F00D;
        end
        if (mem_val && mem_we) begin
            env_mem[int'(mem_addr)] = mem_wdata;
        end
    end

    // Reference model state
    typedef struct {
        int            due;
        bit            is_b;
        logic [DW-1:0] data;
    } resp_t;

    resp_t         resp_q[$];
    logic [DW-1:0] ref_mem [int];

    logic          obs_b_rdy, obs_mem_val, obs_mem_we, obs_b_rvalid;
    logic [AW-1:0] obs_mem_addr;
    logic [DW-1:0] obs_mem_wdata, obs_b_rdata, obs_a_data;
    logic          exp_b_rdy, exp_mem_val, exp_mem_we, exp_b_rvalid, exp_a_hit;
    logic [AW-1:0] exp_mem_addr;
    logic [DW-1:0] exp_data;

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] addr);
        return ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : DW'(addr);
    endfunction

    // One clock cycle: inputs already applied, observe at negedge, advance model
    task automatic step();
        resp_t r;
        logic  granted;
        @(negedge clk);
        obs_b_rdy     = b_rdy;
        obs_mem_val   = mem_val;
        obs_mem_we    = mem_we;
        obs_mem_addr  = mem_addr;
        obs_mem_wdata = mem_wdata;
        obs_b_rvalid  = b_rvalid;
        obs_b_rdata   = b_rdata;
        obs_a_data    = a_data;

        granted      = b_val && !a_val;
        exp_b_rdy    = !a_val;
        exp_mem_val  = a_val || granted;
        exp_mem_we   = granted && b_we;
        exp_mem_addr = a_val ? a_addr : b_addr;

        exp_b_rvalid = 1'b0;
        exp_a_hit    = 1'b0;
        exp_data     = 'x;
        if (!rst) begin
            resp_q.delete();
        end else if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
            r            = resp_q.pop_front();
            exp_data     = r.data;
            exp_b_rvalid = r.is_b;
            exp_a_hit    = !r.is_b;
        end

        if (exp_mem_we) begin
            ref_mem[int'(b_addr)] = b_wdata;
        end else if (rst) begin
            if (a_val) begin
                resp_q.push_back('{due: cyc + LAT, is_b: 1'b0, data: ref_read(a_addr)});
            end else if (granted) begin
                resp_q.push_back('{due: cyc + LAT, is_b: 1'b1, data: ref_read(b_addr)});
            end
        end

`ifdef IMAGE_ARB_STATS_EN
        obs_stat = stat_stall;
        if (!rst) model_stall = 32'd0;
        exp_stat = model_stall;
        if (!rst || stat_clr) begin
            model_stall = 32'd0;
        end else if (b_val && a_val && model_stall != 32'hFFFF_FFFF) begin
            model_stall = model_stall + 32'd1;
        end
`endif

        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        a_val   = 1'b0;
        a_addr  = '0;
        b_val   = 1'b0;
        b_we    = 1'b0;
        b_addr  = '0;
        b_wdata = '0;
    endtask

    // Reset state, and the memory command still follows the inputs in reset
    task automatic test_reset();
        rst = 1'b0;
        set_idle();
`ifdef IMAGE_ARB_STATS_EN
        stat_clr    = 1'b0;
        model_stall = 32'd0;
`endif
        step();
        checks++; if (obs_b_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b, expected 0", obs_b_rvalid); else passes++;
        checks++; if (obs_b_rdy !== 1'b1) $display("FAIL reset_rdy: got %b, expected 1", obs_b_rdy); else passes++;
        checks++; if (obs_mem_val !== 1'b0) $display("FAIL reset_mem_val: got %b, expected 0", obs_mem_val); else passes++;
`ifdef IMAGE_ARB_STATS_EN
        checks++; if (obs_stat !== 32'd0) $display("FAIL reset_stat: got %0d, expected 0", obs_stat); else passes++;
`endif
        a_val = 1'b1; a_addr = 16'h0012; b_val = 1'b1; b_we = 1'b0; b_addr = 16'h0033;
        step();
        checks++; if (obs_b_rdy !== 1'b0) $display("FAIL reset_a_rdy: got %b, expected 0", obs_b_rdy); else passes++;
        checks++; if (obs_mem_val !== 1'b1) $display("FAIL reset_a_mem_val: got %b, expected 1", obs_mem_val); else passes++;
        checks++; if (obs_mem_addr !== 16'h0012) $display("FAIL reset_a_addr: got %h, expected 0012", obs_mem_addr); else passes++;
        set_idle();
        rst = 1'b1;
        repeat (LAT + 1) begin
            step();
            checks++; if (obs_b_rvalid !== 1'b0) $display("FAIL reset_release_rvalid: got %b, expected 0", obs_b_rvalid); else passes++;
        end
    endtask

    // Write 0xAA to address 5, one idle cycle, then read it back
    task automatic test_write_read();
        b_val = 1'b1; b_we = 1'b1; b_addr = 16'd5; b_wdata = 64'hAA;
        step();
        checks++; if (obs_mem_we !== 1'b1) $display("FAIL wr_mem_we: got %b, expected 1", obs_mem_we); else passes++;
        checks++; if (obs_mem_addr !== 16'd5) $display("FAIL wr_mem_addr: got %h, expected 0005", obs_mem_addr); else passes++;
        checks++; if (obs_mem_wdata !== 64'hAA) $display("FAIL wr_mem_wdata: got %h, expected aa", obs_mem_wdata); else passes++;
        set_idle();
        step();
        checks++; if (obs_mem_we !== 1'b0) $display("FAIL wr_one_cycle: got %b, expected 0", obs_mem_we); else passes++;
        b_val = 1'b1; b_we = 1'b0; b_addr = 16'd5;
        step();
        checks++; if (obs_mem_we !== 1'b0 || obs_mem_val !== 1'b1) $display("FAIL rd_cmd: got we=%b val=%b, expected we=0 val=1", obs_mem_we, obs_mem_val); else passes++;
        set_idle();
        for (int k = 1; k <= LAT + 1; k++) begin
            step();
            if (k == LAT) begin
                checks++; if (obs_b_rvalid !== 1'b1) $display("FAIL rd_rvalid: got %b, expected 1", obs_b_rvalid); else passes++;
                checks++; if (obs_b_rdata !== 64'hAA) $display("FAIL rd_rdata: got %h, expected aa", obs_b_rdata); else passes++;
            end else begin
                checks++; if (obs_b_rvalid !== 1'b0) $display("FAIL rd_rvalid_off: got %b, expected 0 at offset %0d", obs_b_rvalid, k); else passes++;
            end
        end
    endtask

    // Ten cycles of A traffic hold off a pending B read, which goes on cycle 11
    task automatic test_a_priority();
        int b_seen = 0;
        b_val = 1'b1; b_we = 1'b0; b_addr = 16'd5;
        for (int k = 0; k < 16; k++) begin
            if (k < 10) begin
                a_val = 1'b1; a_addr = 16'(100 + k);
            end else begin
                a_val = 1'b0;
            end
            if (k > 10) b_val = 1'b0;
            step();
            if (k < 10) begin
                checks++; if (obs_b_rdy !== 1'b0) $display("FAIL prio_rdy: got %b, expected 0 at cycle %0d", obs_b_rdy, k); else passes++;
                checks++; if (obs_mem_addr !== 16'(100 + k) || obs_mem_we !== 1'b0) $display("FAIL prio_mem: got addr %h we %b, expected addr %h we 0", obs_mem_addr, obs_mem_we, 16'(100 + k)); else passes++;
            end
            if (k == 10) begin
                checks++; if (obs_mem_val !== 1'b1 || obs_mem_addr !== 16'd5) $display("FAIL prio_b_xfer: got val %b addr %h, expected val 1 addr 0005", obs_mem_val, obs_mem_addr); else passes++;
            end
            if (k >= LAT && k < 10 + LAT) begin
                checks++; if (obs_a_data !== 64'(100 + k - LAT)) $display("FAIL prio_a_data: got %h, expected %h", obs_a_data, 64'(100 + k - LAT)); else passes++;
            end
            if (obs_b_rvalid === 1'b1) begin
                b_seen++;
                checks++; if (k != 10 + LAT || obs_b_rdata !== 64'hAA) $display("FAIL prio_b_resp: got cycle %0d data %h, expected cycle %0d data aa", k, obs_b_rdata, 10 + LAT); else passes++;
            end
        end
        checks++; if (b_seen !== 1) $display("FAIL prio_b_count: got %0d, expected 1", b_seen); else passes++;
    endtask

    // A and B reads alternate over addresses 0..15
    task automatic test_alternating();
        int b_seen = 0;
        for (int k = 0; k < 16 + LAT + 1; k++) begin
            set_idle();
            if (k < 16) begin
                if (k % 2 == 0) begin
                    a_val = 1'b1; a_addr = 16'(k);
                end else begin
                    b_val = 1'b1; b_addr = 16'(k);
                end
            end
            step();
            if (obs_b_rvalid === 1'b1) b_seen++;
            checks++; if (obs_b_rvalid !== (k >= LAT && k < 16 + LAT && ((k - LAT) % 2 == 1))) $display("FAIL alt_rvalid: got %b at cycle %0d", obs_b_rvalid, k); else passes++;
            if (exp_b_rvalid) begin
                checks++; if (obs_b_rdata !== exp_data) $display("FAIL alt_b_data: got %h, expected %h", obs_b_rdata, exp_data); else passes++;
            end
            if (exp_a_hit) begin
                checks++; if (obs_a_data !== exp_data) $display("FAIL alt_a_data: got %h, expected %h", obs_a_data, exp_data); else passes++;
            end
        end
        checks++; if (b_seen !== 8) $display("FAIL alt_b_count: got %0d, expected 8", b_seen); else passes++;
    endtask

    // Four back-to-back B reads of addresses 1..4
    task automatic test_back_to_back();
        for (int j = 0; j < 8; j++) begin
            set_idle();
            if (j < 4) begin
                b_val = 1'b1; b_addr = 16'(j + 1);
            end
            step();
            if (j < 4) begin
                checks++; if (obs_mem_addr !== 16'(j + 1) || obs_mem_val !== 1'b1) $display("FAIL b2b_accept: got val %b addr %h, expected val 1 addr %h", obs_mem_val, obs_mem_addr, 16'(j + 1)); else passes++;
            end
            checks++; if (obs_b_rvalid !== (j >= LAT && j < LAT + 4)) $display("FAIL b2b_rvalid: got %b at cycle %0d", obs_b_rvalid, j); else passes++;
            if (j >= LAT && j < LAT + 4) begin
                checks++; if (obs_b_rdata !== 64'(j - LAT + 1)) $display("FAIL b2b_rdata: got %h, expected %h", obs_b_rdata, 64'(j - LAT + 1)); else passes++;
            end
        end
    endtask

    // Reset one cycle after two B reads drops both responses
    task automatic test_reset_drop();
        set_idle();
        b_val = 1'b1; b_addr = 16'd9;
        step();
        b_addr = 16'd10;
        step();
        set_idle();
        rst = 1'b0;
        step();
        checks++; if (obs_b_rvalid !== 1'b0) $display("FAIL drop_in_reset: got %b, expected 0", obs_b_rvalid); else passes++;
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++; if (obs_b_rvalid !== 1'b0) $display("FAIL drop_after_release: got %b, expected 0 at cycle %0d", obs_b_rvalid, k); else passes++;
        end
    endtask

    // Random mix; the requester holds a stalled B request stable
    task automatic test_random();
        logic pend = 1'b0;
        for (int k = 0; k < 400; k++) begin
            a_val  = ($urandom_range(0, 2) == 0);
            a_addr = 16'($urandom_range(0, 31));
            if (!pend) begin
                b_val   = ($urandom_range(0, 1) == 1);
                b_we    = ($urandom_range(0, 2) == 0);
                b_addr  = 16'($urandom_range(0, 31));
                b_wdata = {$urandom, $urandom};
            end
            step();
            pend = b_val && a_val;
            checks++; if (obs_b_rdy !== exp_b_rdy) $display("FAIL rnd_rdy: got %b, expected %b", obs_b_rdy, exp_b_rdy); else passes++;
            checks++; if (obs_mem_val !== exp_mem_val || obs_mem_we !== exp_mem_we) $display("FAIL rnd_cmd: got val %b we %b, expected val %b we %b", obs_mem_val, obs_mem_we, exp_mem_val, exp_mem_we); else passes++;
            if (exp_mem_val) begin
                checks++; if (obs_mem_addr !== exp_mem_addr) $display("FAIL rnd_addr: got %h, expected %h", obs_mem_addr, exp_mem_addr); else passes++;
            end
            if (exp_mem_we) begin
                checks++; if (obs_mem_wdata !== b_wdata) $display("FAIL rnd_wdata: got %h, expected %h", obs_mem_wdata, b_wdata); else passes++;
            end
            checks++; if (obs_b_rvalid !== exp_b_rvalid) $display("FAIL rnd_rvalid: got %b, expected %b", obs_b_rvalid, exp_b_rvalid); else passes++;
            if (exp_b_rvalid) begin
                checks++; if (obs_b_rdata !== exp_data) $display("FAIL rnd_b_data: got %h, expected %h", obs_b_rdata, exp_data); else passes++;
            end
            if (exp_a_hit) begin
                checks++; if (obs_a_data !== exp_data) $display("FAIL rnd_a_data: got %h, expected %h", obs_a_data, exp_data); else passes++;
            end
        end
        set_idle();
        repeat (LAT + 1) step();
    endtask

`ifdef IMAGE_ARB_STATS_EN
    // Seven stalled cycles, then a clear that coincides with a stall
    task automatic test_stats();
        set_idle();
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        step();
        checks++; if (obs_stat !== 32'd0) $display("FAIL stat_cleared: got %0d, expected 0", obs_stat); else passes++;
        a_val = 1'b1; b_val = 1'b1; b_we = 1'b0; b_addr = 16'd3;
        repeat (7) step();
        a_val = 1'b0;
        step();
        checks++; if (obs_stat !== 32'd7) $display("FAIL stat_seven: got %0d, expected 7", obs_stat); else passes++;
        checks++; if (obs_stat !== exp_stat) $display("FAIL stat_model: got %0d, expected %0d", obs_stat, exp_stat); else passes++;
        a_val = 1'b1; b_val = 1'b1; stat_clr = 1'b1;
        step();
        stat_clr = 1'b0; a_val = 1'b0;
        step();
        checks++; if (obs_stat !== 32'd0) $display("FAIL stat_clr_wins: got %0d, expected 0", obs_stat); else passes++;
        set_idle();
        repeat (LAT + 1) step();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < LAT; i++) rd_pipe[i] = 64'hDEAD_BEEF_0BAD_F00D;
        test_reset();
        test_write_read();
        test_a_priority();
        test_alternating();
        test_back_to_back();
        test_reset_drop();
        test_random();
`ifdef IMAGE_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
